bitmap_serial_encoder: RTL
==========================

// Module: bitmap_serial_encoder
// PURPOSE
//  Inverse of the one-hot decoder: accepts a multi-hot bitmap and emits the binary index of
//  each set bit, lowest first, one per output handshake. Used where a select/valid bitmap
//  drives PE-column or buffer-row indices. Streaming valid/ready on both sides.
// PARAMETERS
//  IN_DW   8                bitmap width (>=2)
//  OUT_DW  $clog2(IN_DW)    index width
// PORTS
//  clk        in   1       clock, rising edge
//  rst        in   1       reset, asynchronous, active-high
//  in_valid   in   1       bitmap offered
//  in_ready   out  1       block can accept a bitmap
//  in_data    in   IN_DW   bitmap
//  out_valid  out  1       index beat valid
//  out_ready  in   1       downstream accepts beat
//  out_idx    out  OUT_DW  index of current set bit
//  out_last   out  1       final beat of current bitmap
//  out_none   out  1       bitmap was all-zero (single beat)
//  out_cnt    out  OUT_DW+1  popcount of current bitmap (only with SERIAL_ENC_COUNT_EN)
// BEHAVIOUR
//  - Reset (async, rst=1): state=IDLE, in_ready=0 while rst=1 and 1 in the first cycle after release,
//    out_valid=0, out_idx=0, out_last=0, out_none=0, out_cnt=0, internal bitmap=0.
//  - FSM: IDLE -> EMIT on in_valid&&in_ready; EMIT -> EMIT on out handshake with more bits;
//    EMIT -> IDLE on out handshake of out_last beat. in_ready = (state==IDLE).
//  - Accept edge N: bitmap registered; out_valid=1 from cycle N+1 (latency 1) with index of
//    lowest set bit. No back-to-back overlap: next bitmap accepted earliest cycle after last beat.
//  - Each out handshake clears the emitted bit; next beat presents next lowest set bit in the
//    following cycle. One beat per set bit, ascending index. Max throughput 1 beat/cycle.
//  - out_last=1 when exactly one bit remains (current beat is final).
//  - All-zero bitmap: one beat, out_idx=0, out_none=1, out_last=1.
//  - out_idx/out_last/out_none/out_cnt held stable while out_valid && !out_ready.
//  - in_data ignored when in_ready=0; in_valid without in_ready has no effect.
//  - Bit IN_DW-1 set: out_idx = IN_DW-1 (no wrap). Non-power-of-2 IN_DW legal.
//  - rst asserted mid-EMIT: remaining beats discarded, return to reset values immediately.
// CONFIGURATION
//  SERIAL_ENC_COUNT_EN defined: out_cnt port present = popcount of accepted bitmap, captured
//  at accept, constant on every beat of that bitmap (0 for all-zero bitmap).
//  Not defined: out_cnt port and popcount logic absent; all other behaviour identical.
// STRUCTURE
//  Shared package/include enc_defs: FSM state localparams (ST_IDLE, ST_EMIT), 1-bit encoding;
//  function lsb_index(bitmap) and popcount width constant.
//  One sub-module: lsb_prio_enc (combinational, IN_DW bitmap -> OUT_DW index + any-set flag).
//  Top holds FSM, bitmap register, output registers, clear-lowest-bit (bm & (bm-1)).
// TESTING
//  1 in_data=8'b1010_0100, out_ready=1 -> idx 2,5,7 on consecutive cycles; last only on 7.
//  2 in_data=8'h00 -> single beat idx=0, out_none=1, out_last=1; in_ready back next cycle.
//  3 in_data=8'h81, out_ready low 3 cycles on first beat -> idx=0 held stable, then 0,7.
//  4 in_data=8'hFF with SERIAL_ENC_COUNT_EN -> 8 beats idx 0..7, out_cnt=8 on all.
//  5 rst pulse mid-EMIT of 8'hF0 after idx 4 -> out_valid=0 at once, in_ready=1 after release.
//  6 in_valid held high with 8'h03 then 8'h40 -> beats 0,1(last),6(last); in_ready=0 during EMIT.

Source files
------------

// File: rtl/enc_defs.sv
// Shared definitions for the bitmap serial encoder:
// FSM state encoding, lowest-set-bit search and popcount width helper.
package enc_defs;

    // Two-state emitter: waiting for a bitmap, or streaming its indices.
    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_EMIT = 1'b1
    } state_t;

    // Widest bitmap the lsb_index helper can search.
    localparam int MAX_DW = 64;
    localparam int MAX_IW = 6;

    // Index of the lowest set bit; 0 when the bitmap is all-zero.
    function automatic logic [MAX_IW-1:0] lsb_index(input logic [MAX_DW-1:0] bm);
        logic [MAX_IW-1:0] idx;
        idx = '0;
        for (int i = MAX_DW - 1; i >= 0; i--) begin
            if (bm[i]) idx = MAX_IW'(i);
        end
        return idx;
    endfunction

    // Width needed to hold a popcount of a dw-bit bitmap (0..dw inclusive).
    function automatic int cnt_width(input int dw);
        return $clog2(dw) + 1;
    endfunction

endpackage

// File: rtl/lsb_prio_enc.sv
// Combinational lowest-first priority encoder: bitmap -> index of lowest set
// bit plus an any-set flag. The index is 0 when no bit is set.
module lsb_prio_enc
    import enc_defs::*;
#(
    parameter int IN_DW  = 8,
    parameter int OUT_DW = $clog2(IN_DW)
) (
    input  logic [IN_DW-1:0]  bitmap_i,
    output logic [OUT_DW-1:0] idx_o,
    output logic              any_o
);

    logic [MAX_DW-1:0] bm_ext;

    // Zero-extend into the helper's fixed search width.
    always_comb begin
        bm_ext = MAX_DW'(bitmap_i);
    end

    assign idx_o = OUT_DW'(lsb_index(bm_ext));
    assign any_o = |bitmap_i;

endmodule

// File: rtl/bitmap_serial_encoder.sv
// Bitmap serial encoder: accepts a multi-hot bitmap and emits the binary
// index of each set bit, lowest first, one per output handshake.
// An all-zero bitmap produces a single beat flagged with out_none.
// Optional feature macro: SERIAL_ENC_COUNT_EN adds the out_cnt port carrying
// the popcount of the bitmap being emitted.
//
// Handshakes: a transfer happens on a rising edge where valid && ready.
// out_valid and the beat fields are registered and stay stable while
// out_ready is low; in_ready is high only while idle and out of reset.
module bitmap_serial_encoder
    import enc_defs::*;
#(
    parameter int IN_DW  = 8,
    parameter int OUT_DW = $clog2(IN_DW)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [IN_DW-1:0]  in_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [OUT_DW-1:0] out_idx,
    output logic              out_last,
    output logic              out_none
`ifdef SERIAL_ENC_COUNT_EN
   ,output logic [OUT_DW:0]   out_cnt
`endif
);

    state_t             state_q;
    logic [IN_DW-1:0]   bm_q;
    logic [IN_DW-1:0]   bm_d;
    logic [IN_DW-1:0]   enc_in;
    logic [IN_DW-1:0]   enc_rest;
    logic [OUT_DW-1:0]  enc_idx;
    logic               enc_any;
    logic               out_valid_q;
    logic [OUT_DW-1:0]  out_idx_q;
    logic               out_last_q;
    logic               out_none_q;
    logic               accept;
    logic               final_fire;

    // Remaining bitmap once the currently presented (lowest) bit is emitted.
    assign bm_d = bm_q & (bm_q - IN_DW'(1));

    // One encoder serves both the incoming bitmap (idle) and the shrinking
    // stored bitmap (emitting), since only one can advance per cycle.
    assign enc_in   = (state_q == ST_IDLE) ? in_data : bm_d;
    assign enc_rest = enc_in & (enc_in - IN_DW'(1));

    lsb_prio_enc #(
        .IN_DW  (IN_DW),
        .OUT_DW (OUT_DW)
    ) u_enc (
        .bitmap_i (enc_in),
        .idx_o    (enc_idx),
        .any_o    (enc_any)
    );

    assign in_ready   = (state_q == ST_IDLE) && !rst;
    assign accept     = in_valid && in_ready;
    assign final_fire = (state_q == ST_EMIT) && out_ready && out_last_q;

    // FSM with registered beat outputs: load on accept, advance on each beat.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            bm_q        <= '0;
            out_valid_q <= 1'b0;
            out_idx_q   <= '0;
            out_last_q  <= 1'b0;
            out_none_q  <= 1'b0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    if (accept) begin
                        state_q     <= ST_EMIT;
                        bm_q        <= in_data;
                        out_valid_q <= 1'b1;
                        out_idx_q   <= enc_idx;
                        out_last_q  <= (enc_rest == '0);
                        out_none_q  <= !enc_any;
                    end
                end
                ST_EMIT: begin
                    if (out_ready) begin
                        if (out_last_q) begin
                            state_q     <= ST_IDLE;
                            bm_q        <= '0;
                            out_valid_q <= 1'b0;
                            out_idx_q   <= '0;
                            out_last_q  <= 1'b0;
                            out_none_q  <= 1'b0;
                        end else begin
                            bm_q       <= bm_d;
                            out_idx_q  <= enc_idx;
                            out_last_q <= (enc_rest == '0);
                        end
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign out_idx   = out_idx_q;
    assign out_last  = out_last_q;
    assign out_none  = out_none_q;

`ifdef SERIAL_ENC_COUNT_EN
    localparam int CNT_W = cnt_width(IN_DW);

    logic [CNT_W-1:0] pop_in;
    logic [CNT_W-1:0] cnt_q;

    // Popcount of the offered bitmap.
    always_comb begin
        pop_in = '0;
        for (int i = 0; i < IN_DW; i++) begin
            pop_in = pop_in + CNT_W'(in_data[i]);
        end
    end

    // Count captured at accept and held across every beat of that bitmap.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else if (accept) begin
            cnt_q <= pop_in;
        end else if (final_fire) begin
            cnt_q <= '0;
        end
    end

    assign out_cnt = cnt_q;
`endif

endmodule
